jump_fetch_ctrl: RTL and testbench

- Sequences instruction fetch and control-flow redirection for the RV32I core.
- Owns the PC and issues single-outstanding fetch requests to instruction memory.
- Presents each fetched word to the jump decoder/execute stage, then applies the decoded JAL/JALR/no-jump result to select the next PC.
- Produces the rd link value, inserts post-redirect bubbles, flags misaligned jump targets, and counts taken jumps.

---
 rtl/jump_fetch_ctrl_pkg.sv | 41 ++++
 rtl/jump_fetch_ctrl_if.sv | 43 ++++
 rtl/jump_fetch_ctrl_target.sv | 41 ++++
 rtl/jump_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_jump_fetch_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/jump_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// jump_fetch_ctrl_pkg
// Shared definitions for the fetch / jump-redirect controller:
//   - `JMP_NOP / `JAL / `JALR jump-class encodings (as produced by the decoder)
//   - fetch FSM state enum
//   - jump_result_t: combinational result of the target calculation
//   - sign-extension helpers for the JAL (21-bit) and JALR (12-bit) immediates
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef JMP_NOP
`define JMP_NOP 2'b00
`define JAL     2'b01
`define JALR    2'b10
`endif

package jump_fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_REQ    = 3'd0,
      ST_WAIT   = 3'd1,
      ST_HOLD   = 3'd2,
      ST_BUBBLE = 3'd3,
      ST_TRAP   = 3'd4
   } fetch_state_t;

   typedef struct packed {
      logic        taken;     // JAL or JALR decoded
      logic        misalign;  // taken and target[1] set
      logic [31:0] target;    // redirect address
      logic [31:0] link;      // inst_pc + 4
   } jump_result_t;

   function automatic logic [31:0] sext21(input logic [20:0] v);
      return {{11{v[20]}}, v};
   endfunction

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/jump_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// jump_fetch_ctrl_if
// Bundles the instruction-memory handshake, the downstream instruction /
// jump-decode handshake and the link write-back of jump_fetch_ctrl.
//   master : the fetch controller (drives requests, instruction, link)
//   slave  : the environment (memory, decoder, register file)
// -----------------------------------------------------------------------------
interface jump_fetch_ctrl_if;
   // instruction memory
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   // downstream instruction and decoded jump info
   logic        inst_valid;
   logic [31:0] inst_code;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic [1:0]  jump_control;
   logic [20:0] jump_imm;
   logic [31:0] rs1_data;
   // link write-back
   logic        link_we;
   logic [31:0] link_data;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output inst_valid, inst_code, inst_pc,
      input  inst_ready, jump_control, jump_imm, rs1_data,
      output link_we, link_data
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  inst_valid, inst_code, inst_pc,
      output inst_ready, jump_control, jump_imm, rs1_data,
      input  link_we, link_data
   );

endinterface

// File: rtl/jump_fetch_ctrl_target.sv
// -----------------------------------------------------------------------------
// jump_target_calc
// Purely combinational jump evaluation for the instruction currently held.
// Ports:
//   inst_pc      in  32  PC of the held instruction
//   jump_control in  2   decoded class (2'b11 behaves as no-jump)
//   jump_imm     in  21  JAL: 21-bit signed; JALR: [11:0] 12-bit signed
//   rs1_data     in  32  rs1 value for JALR
//   result       out     taken / misalign / target / link
// -----------------------------------------------------------------------------
module jump_target_calc
   import jump_fetch_ctrl_pkg::*;
(
   input  logic [31:0]  inst_pc,
   input  logic [1:0]   jump_control,
   input  logic [20:0]  jump_imm,
   input  logic [31:0]  rs1_data,
   output jump_result_t result
);

   always_comb begin
      result        = '0;
      result.link   = inst_pc + 32'd4;
      case (jump_control)
         `JAL: begin
            result.taken  = 1'b1;
            result.target = inst_pc + sext21(jump_imm);
         end
         `JALR: begin
            result.taken  = 1'b1;
            // JALR always clears bit 0 of the computed address
            result.target = (rs1_data + sext12(jump_imm[11:0])) & ~32'h1;
         end
         default: ;
      endcase
      // Only bit 1 matters: bit 0 is either cleared (JALR) or an odd JAL
      // offset that the core does not trap on.
      result.misalign = result.taken & result.target[1];
   end

endmodule

// File: rtl/jump_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// jump_fetch_ctrl
// Owns the PC, issues single-outstanding fetches, presents each word to the
// jump decoder and applies the JAL/JALR/no-jump result to pick the next PC.
// Generates the link write, post-redirect bubbles, a sticky misalign trap and
// a saturating taken-jump counter.
// Ports:
//   clk, rst_n     core clock / asynchronous active-low reset
//   bus            jump_fetch_ctrl_if.master (imem, instruction, link)
//   misalign_trap  sticky flag, taken target had bit[1] set
//   trap_pc        inst_pc of the faulting jump
//   jump_count     saturating count of taken jumps
// -----------------------------------------------------------------------------
module jump_fetch_ctrl
   import jump_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC         = 32'h0000_0000,
   parameter int          REDIRECT_BUBBLES = 1,
   parameter int          CNT_W            = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   jump_fetch_ctrl_if.master bus,
   output logic             misalign_trap,
   output logic [31:0]      trap_pc,
   output logic [CNT_W-1:0] jump_count
);

   // last value of the bubble counter before returning to REQ
   localparam int          BUB_LAST_I = (REDIRECT_BUBBLES > 0) ? REDIRECT_BUBBLES - 1 : 0;
   localparam logic [3:0]  BUB_LAST   = BUB_LAST_I[3:0];

   fetch_state_t state_reg;
   logic [31:0]  pc_reg;
   logic [3:0]   bubble_cnt_reg;
   jump_result_t jres;

   jump_target_calc u_target (
      .inst_pc      (bus.inst_pc),
      .jump_control (bus.jump_control),
      .jump_imm     (bus.jump_imm),
      .rs1_data     (bus.rs1_data),
      .result       (jres)
   );

   // Request side is decoded straight from state so it is up as soon as
   // reset releases.
   assign bus.imem_req_valid = (state_reg == ST_REQ);
   assign bus.imem_req_addr  = pc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_REQ;
         pc_reg         <= RESET_PC;
         bubble_cnt_reg <= '0;
         bus.inst_valid <= 1'b0;
         bus.inst_code  <= '0;
         bus.inst_pc    <= RESET_PC;
         bus.link_we    <= 1'b0;
         bus.link_data  <= '0;
         misalign_trap  <= 1'b0;
         trap_pc        <= '0;
         jump_count     <= '0;
      end else begin
         bus.link_we <= 1'b0;
         case (state_reg)
            ST_REQ: begin
               if (bus.imem_req_ready) begin
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.imem_rsp_valid) begin
                  bus.inst_code  <= bus.imem_rsp_data;
                  bus.inst_pc    <= pc_reg;
                  bus.inst_valid <= 1'b1;
                  state_reg      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // jump inputs are only meaningful on the accept cycle
               if (bus.inst_ready) begin
                  bus.inst_valid <= 1'b0;
                  if (!jres.taken) begin
                     pc_reg    <= pc_reg + 32'd4;
                     state_reg <= ST_REQ;
                  end else if (jres.misalign) begin
                     misalign_trap <= 1'b1;
                     trap_pc       <= bus.inst_pc;
                     state_reg     <= ST_TRAP;
                  end else begin
                     pc_reg        <= jres.target;
                     bus.link_we   <= 1'b1;
                     bus.link_data <= jres.link;
                     if (jump_count != {CNT_W{1'b1}}) begin
                        jump_count <= jump_count + 1'b1;
                     end
                     bubble_cnt_reg <= '0;
                     state_reg      <= (REDIRECT_BUBBLES > 0) ? ST_BUBBLE : ST_REQ;
                  end
               end
            end
            ST_BUBBLE: begin
               if (bubble_cnt_reg == BUB_LAST) begin
                  state_reg <= ST_REQ;
               end else begin
                  bubble_cnt_reg <= bubble_cnt_reg + 4'd1;
               end
            end
            ST_TRAP: begin
               // terminal until reset
               bus.inst_valid <= 1'b0;
            end
            default: state_reg <= ST_TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_jump_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jump_fetch_ctrl
// Directed bench for jump_fetch_ctrl (RESET_PC=0x100, one redirect bubble).
// -----------------------------------------------------------------------------
module tb_jump_fetch_ctrl;

   localparam logic [1:0] C_NOP  = 2'b00;
   localparam logic [1:0] C_JAL  = 2'b01;
   localparam logic [1:0] C_JALR = 2'b10;

   logic        clk;
   logic        rst_n;
   logic        misalign_trap;
   logic [31:0] trap_pc;
   logic [15:0] jump_count;

   int checks = 0;
   int errors = 0;

   jump_fetch_ctrl_if bus ();

   jump_fetch_ctrl #(
      .RESET_PC         (32'h0000_0100),
      .REDIRECT_BUBBLES (1),
      .CNT_W            (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .misalign_trap (misalign_trap),
      .trap_pc       (trap_pc),
      .jump_count    (jump_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // wait (bounded) for a fetch request, then check its address
   task automatic wait_req(input string tag, input logic [31:0] addr);
      int n = 0;
      while (!bus.imem_req_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_req_valid"}, {31'd0, bus.imem_req_valid}, 32'd1);
      chk({tag, "_req_addr"}, bus.imem_req_addr, addr);
   endtask

   // one complete fetch with a zero-wait memory response
   task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
      wait_req(tag, addr);
      bus.imem_req_ready = 1'b1;
      @(negedge clk);
      bus.imem_req_ready = 1'b0;
      chk({tag, "_wait_noreq"}, {31'd0, bus.imem_req_valid}, 32'd0);
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word;
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      chk({tag, "_inst_valid"}, {31'd0, bus.inst_valid}, 32'd1);
      chk({tag, "_inst_code"}, bus.inst_code, word);
      chk({tag, "_inst_pc"}, bus.inst_pc, addr);
      $display("fetch %s addr=%h word=%h", tag, addr, word);
   endtask

   // accept the held instruction with the given decode; junk afterwards
   task automatic accept(input logic [1:0] ctrl, input logic [20:0] imm, input logic [31:0] rs1);
      bus.inst_ready   = 1'b1;
      bus.jump_control = ctrl;
      bus.jump_imm     = imm;
      bus.rs1_data     = rs1;
      @(negedge clk);
      bus.inst_ready   = 1'b0;
      bus.jump_control = C_JAL;
      bus.jump_imm     = 21'h000100;
      bus.rs1_data     = 32'h0000_5550;
      $display("accept ctrl=%0d imm=%h rs1=%h", ctrl, imm, rs1);
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.inst_ready     = 1'b0;
      bus.jump_control   = C_NOP;
      bus.jump_imm       = '0;
      bus.rs1_data       = '0;
      repeat (2) @(negedge clk);

      // reset values
      chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("rst_link_we", {31'd0, bus.link_we}, 32'd0);
      chk("rst_link_data", bus.link_data, 32'd0);
      chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
      chk("rst_trap_pc", trap_pc, 32'd0);
      chk("rst_count", {16'd0, jump_count}, 32'd0);
      chk("rst_inst_code", bus.inst_code, 32'd0);
      chk("rst_inst_pc", bus.inst_pc, 32'h100);
      rst_n = 1'b1;
      #1;
      chk("rel_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("rel_req_addr", bus.imem_req_addr, 32'h100);
      @(negedge clk);

      // memory not ready for 3 cycles: address held
      for (int i = 0; i < 3; i++) begin
         chk("bp_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
         chk("bp_req_addr", bus.imem_req_addr, 32'h100);
         $display("req backpressure cycle %0d addr=%h", i, bus.imem_req_addr);
         @(negedge clk);
      end

      // NOP stream
      fetch("nop0", 32'h100, 32'h0000_0013);
      accept(C_NOP, 21'h0, 32'h0);
      chk("nop0_no_link", {31'd0, bus.link_we}, 32'd0);
      fetch("nop1", 32'h104, 32'h0000_0013);
      accept(C_NOP, 21'h0, 32'h0);
      fetch("nop2", 32'h108, 32'h0000_0013);
      accept(2'b11, 21'h000040, 32'h0);   // 2'b11 acts as NOP

      // JALR to 0x200
      fetch("jalr200", 32'h10C, 32'h0000_80E7);
      accept(C_JALR, 21'h0, 32'h0000_0200);
      chk("jalr200_link_we", {31'd0, bus.link_we}, 32'd1);
      chk("jalr200_link_data", bus.link_data, 32'h110);
      chk("jalr200_count", {16'd0, jump_count}, 32'd1);
      chk("jalr200_bubble", {31'd0, bus.imem_req_valid}, 32'd0);
      @(negedge clk);

      // JAL -16 at 0x200
      fetch("jal", 32'h200, 32'hFF1F_F0EF);
      accept(C_JAL, 21'h1FFFF0, 32'h0);
      chk("jal_link_we", {31'd0, bus.link_we}, 32'd1);
      chk("jal_link_data", bus.link_data, 32'h204);
      chk("jal_count", {16'd0, jump_count}, 32'd2);
      chk("jal_bubble", {31'd0, bus.imem_req_valid}, 32'd0);
      @(negedge clk);
      chk("jal_after_req", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("jal_after_addr", bus.imem_req_addr, 32'h1F0);
      chk("jal_link_pulse", {31'd0, bus.link_we}, 32'd0);

      // downstream stall 4 cycles, junk jump inputs present meanwhile
      fetch("stall", 32'h1F0, 32'h0030_80E7);
      bus.jump_control = C_JAL;
      bus.jump_imm     = 21'h000100;
      for (int i = 0; i < 4; i++) begin
         chk("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
         chk("stall_code", bus.inst_code, 32'h0030_80E7);
         chk("stall_pc", bus.inst_pc, 32'h1F0);
         $display("inst backpressure cycle %0d pc=%h", i, bus.inst_pc);
         @(negedge clk);
      end
      accept(C_JALR, 21'h000003, 32'h0000_1001);
      chk("jalr1004_link_data", bus.link_data, 32'h1F4);
      chk("jalr1004_count", {16'd0, jump_count}, 32'd3);
      @(negedge clk);

      // misaligned JALR -> trap
      fetch("trap", 32'h1004, 32'h0020_80E7);
      accept(C_JALR, 21'h000002, 32'h0000_1000);
      chk("trap_flag", {31'd0, misalign_trap}, 32'd1);
      chk("trap_pc", trap_pc, 32'h1004);
      chk("trap_no_link", {31'd0, bus.link_we}, 32'd0);
      chk("trap_count", {16'd0, jump_count}, 32'd3);
      for (int i = 0; i < 5; i++) begin
         chk("trap_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
         chk("trap_no_valid", {31'd0, bus.inst_valid}, 32'd0);
         $display("trap idle cycle %0d", i);
         @(negedge clk);
      end

      // reset while waiting for a response; late response must be dropped
      rst_n = 1'b0;
      #1;
      chk("rst2_trap", {31'd0, misalign_trap}, 32'd0);
      chk("rst2_count", {16'd0, jump_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_req("rst2", 32'h100);
      bus.imem_req_ready = 1'b1;
      @(negedge clk);
      bus.imem_req_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h0BAD_0BAD;
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      chk("late_rsp_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("late_rsp_req", {31'd0, bus.imem_req_valid}, 32'd1);
      $display("late response dropped check");
      fetch("restart", 32'h100, 32'h0000_0013);
      accept(C_NOP, 21'h0, 32'h0);
      wait_req("restart_next", 32'h104);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
